// File: rtl/dma_pkg.sv
// Shared definitions for the DMA I/O peripheral: FSM states and transfer
// direction encodings.
package dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } dma_state_t;

    localparam logic MODE_SRC = 1'b0;
    localparam logic MODE_SNK = 1'b1;

    localparam int WAIT_W = 4;

endpackage

// File: rtl/dma_byte_fifo.sv
// Byte FIFO with a combinational head so the bus side can present data in
// the same cycle as the read strobe.
module dma_byte_fifo #(
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    wdata,
    output logic [7:0]    head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr_reg];
    assign count   = count_reg;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/dma_io_periph.sv
// DMA-capable I/O peripheral: a byte FIFO bridged between a device-side
// valid/ready port and an 8237-style DREQ/DACK/IOR/IOW bus with wait states.
module dma_io_periph
    import dma_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int WAIT_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       MODE,
    input  logic       DACK,
    input  logic       IOR,
    input  logic       IOW,
    input  logic       EOP,
    input  logic [7:0] Data_in,
    output logic [7:0] Data_out,
    output logic       DREQ,
    output logic       RDY,
    input  logic [7:0] DEV_WDATA,
    input  logic       DEV_WVALID,
    output logic       DEV_WREADY,
    output logic [7:0] DEV_RDATA,
    output logic       DEV_RVALID,
    input  logic       DEV_RREADY,
    output logic       DONE,
    input  logic       DONE_CLR
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]     DEPTH_C   = CW'(DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);

    dma_state_t        state_reg;
    dma_state_t        state_next;
    logic [WAIT_W-1:0] wait_reg;
    logic [WAIT_W-1:0] wait_next;
    logic              mode_reg;
    logic              mode_eff;
    logic              srst;

    logic [7:0]    fifo_head;
    logic [7:0]    fifo_wdata;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;
    logic          is_src;
    logic          avail;
    logic          bus_byte;
    logic          dev_push;
    logic          dev_pop;

    assign srst = ~RST;

    // Direction follows MODE only while idle; elsewhere the latched copy rules.
    assign mode_eff = (state_reg == ST_IDLE) ? MODE : mode_reg;
    assign is_src   = (mode_eff == MODE_SRC);
    assign avail    = is_src ? (fifo_count != '0) : (fifo_count < DEPTH_C);

    assign RDY  = !((state_reg == ST_XFER) && (wait_reg != '0));
    assign DONE = (state_reg == ST_DONE);

    assign bus_byte = (state_reg == ST_XFER) && DACK && RDY &&
                      (is_src ? (IOR && !fifo_empty) : (IOW && !fifo_full));

    assign Data_out = (DACK && IOR && !fifo_empty) ? fifo_head : 8'h00;

    assign DEV_WREADY = !fifo_full && (mode_eff == MODE_SRC);
    assign DEV_RVALID = !fifo_empty && (mode_eff == MODE_SNK);
    assign DEV_RDATA  = fifo_head;
    assign dev_push   = DEV_WVALID && DEV_WREADY;
    assign dev_pop    = DEV_RVALID && DEV_RREADY;

    assign fifo_push  = is_src ? dev_push : bus_byte;
    assign fifo_pop   = is_src ? bus_byte : dev_pop;
    assign fifo_wdata = is_src ? DEV_WDATA : Data_in;

    dma_byte_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .srst  (srst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge CLK) begin
        if (srst) begin
            state_reg <= ST_IDLE;
            wait_reg  <= '0;
            mode_reg  <= MODE;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            if (state_reg == ST_IDLE) begin
                mode_reg <= MODE;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        wait_next  = wait_reg;
        DREQ       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (avail) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                DREQ = 1'b1;
                if (DACK) begin
                    state_next = ST_XFER;
                    wait_next  = WAIT_INIT;
                end
            end
            ST_XFER: begin
                DREQ = avail;
                if (bus_byte) begin
                    wait_next = WAIT_INIT;
                end else if (wait_reg != '0) begin
                    wait_next = wait_reg - WAIT_W'(1);
                end
                if (!DACK) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (DONE_CLR) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // End-of-process wins over every other transition; a coincident
        // byte still completes because bus_byte is independent of EOP.
        if (EOP && (state_reg != ST_DONE)) begin
            state_next = ST_DONE;
        end
    end

endmodule

// File: tb/tb_dma_io_periph.sv
// Randomized scoreboard bench for dma_io_periph: a FIFO-order reference of
// expected bus and device bytes, checked by a monitor on every handshake.
module tb_dma_io_periph;

    localparam int W_MAIN = 2;

    logic       CLK;
    logic       RST;
    logic       MODE, DACK, IOR, IOW, EOP, DONE_CLR;
    logic [7:0] Data_in, DEV_WDATA;
    logic       DEV_WVALID, DEV_RREADY;
    logic [7:0] Data_out, DEV_RDATA;
    logic       DREQ, RDY, DEV_WREADY, DEV_RVALID, DONE;

    logic       z_MODE, z_DACK, z_IOR, z_IOW, z_EOP, z_DONE_CLR;
    logic [7:0] z_Data_in, z_DEV_WDATA;
    logic       z_DEV_WVALID, z_DEV_RREADY;
    logic [7:0] z_Data_out, z_DEV_RDATA;
    logic       z_DREQ, z_RDY, z_DEV_WREADY, z_DEV_RVALID, z_DONE;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_bus_q [$];
    logic [7:0] exp_dev_q [$];

    dma_io_periph #(.DEPTH(4), .WAIT_CYCLES(W_MAIN)) dut (
        .CLK(CLK), .RST(RST), .MODE(MODE), .DACK(DACK), .IOR(IOR), .IOW(IOW),
        .EOP(EOP), .Data_in(Data_in), .Data_out(Data_out), .DREQ(DREQ), .RDY(RDY),
        .DEV_WDATA(DEV_WDATA), .DEV_WVALID(DEV_WVALID), .DEV_WREADY(DEV_WREADY),
        .DEV_RDATA(DEV_RDATA), .DEV_RVALID(DEV_RVALID), .DEV_RREADY(DEV_RREADY),
        .DONE(DONE), .DONE_CLR(DONE_CLR)
    );

    dma_io_periph #(.DEPTH(4), .WAIT_CYCLES(0)) dut0 (
        .CLK(CLK), .RST(RST), .MODE(z_MODE), .DACK(z_DACK), .IOR(z_IOR), .IOW(z_IOW),
        .EOP(z_EOP), .Data_in(z_Data_in), .Data_out(z_Data_out), .DREQ(z_DREQ), .RDY(z_RDY),
        .DEV_WDATA(z_DEV_WDATA), .DEV_WVALID(z_DEV_WVALID), .DEV_WREADY(z_DEV_WREADY),
        .DEV_RDATA(z_DEV_RDATA), .DEV_RVALID(z_DEV_RVALID), .DEV_RREADY(z_DEV_RREADY),
        .DONE(z_DONE), .DONE_CLR(z_DONE_CLR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Monitor: a bus read completes on the coming edge whenever the bus sees
    // DACK, IOR and RDY with data available; device pops on valid&ready.
    always @(negedge CLK) begin
        if (RST) begin
            if (DACK && IOR && RDY && DREQ) begin
                if (exp_bus_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL bus_extra_byte actual=%02h required=none", Data_out);
                end else begin
                    chk("bus_data", {24'h0, Data_out}, {24'h0, exp_bus_q.pop_front()});
                end
            end
            if (DEV_RVALID && DEV_RREADY) begin
                if (exp_dev_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL dev_extra_byte actual=%02h required=none", DEV_RDATA);
                end else begin
                    chk("dev_data", {24'h0, DEV_RDATA}, {24'h0, exp_dev_q.pop_front()});
                end
            end
        end
    end

    task automatic wait_dreq(input string nm);
        int n = 0;
        while (!DREQ && n < 20) begin
            tick;
            n++;
        end
        chk(nm, {31'h0, DREQ}, 32'd1);
    endtask

    task automatic open_xfer;
        wait_dreq("dreq_rise");
        DACK = 1'b1;
        tick;
    endtask

    task automatic dev_push_byte(input logic [7:0] b);
        chk("dev_wready", {31'h0, DEV_WREADY}, 32'd1);
        DEV_WDATA  = b;
        DEV_WVALID = 1'b1;
        exp_bus_q.push_back(b);
        tick;
        DEV_WVALID = 1'b0;
    endtask

    task automatic wait_rdy;
        int lows = 0;
        while (!RDY && lows < 20) begin
            tick;
            lows++;
        end
        chk("rdy_wait_states", lows, W_MAIN);
    endtask

    // Reads bytes with IOR held; with sim set, a device push may ride along
    // on the same edge as a bus pop.
    task automatic bus_read(input int n, input bit sim);
        int done_cnt = 0;
        int total    = n;
        logic [7:0] b;
        while (done_cnt < total) begin
            wait_rdy;
            if (sim && (total - done_cnt) < 4 && total < 10 && $urandom_range(0, 1) == 1) begin
                b = 8'($urandom);
                DEV_WDATA  = b;
                DEV_WVALID = 1'b1;
                exp_bus_q.push_back(b);
                total++;
            end
            tick;
            DEV_WVALID = 1'b0;
            done_cnt++;
        end
    endtask

    task automatic bus_write(input int n, input logic [7:0] bytes [4]);
        for (int i = 0; i < n; i++) begin
            Data_in = bytes[i];
            IOW     = 1'b1;
            wait_rdy;
            exp_dev_q.push_back(bytes[i]);
            tick;
        end
        IOW = 1'b0;
    endtask

    task automatic drain(input int n);
        int pops = 0;
        int cyc  = 0;
        while (pops < n && cyc < 40) begin
            DEV_RREADY = 1'($urandom_range(0, 1));
            if (DEV_RREADY && DEV_RVALID) pops++;
            tick;
            cyc++;
        end
        DEV_RREADY = 1'b0;
        chk("drain_count", pops, n);
        chk("rvalid_after_drain", {31'h0, DEV_RVALID}, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] bytes [4];
        logic [7:0] b0, b1;
        int k;
        bit m;

        RST = 1'b0; MODE = 1'b0; DACK = 1'b0; IOR = 1'b0; IOW = 1'b0; EOP = 1'b0;
        DONE_CLR = 1'b0; Data_in = 8'h00; DEV_WDATA = 8'h00; DEV_WVALID = 1'b0; DEV_RREADY = 1'b0;
        z_MODE = 1'b0; z_DACK = 1'b0; z_IOR = 1'b0; z_IOW = 1'b0; z_EOP = 1'b0;
        z_DONE_CLR = 1'b0; z_Data_in = 8'h00; z_DEV_WDATA = 8'h00; z_DEV_WVALID = 1'b0;
        z_DEV_RREADY = 1'b0;
        tick;
        tick;
        chk("rst_dreq", {31'h0, DREQ}, 32'd0);
        chk("rst_rdy", {31'h0, RDY}, 32'd1);
        chk("rst_done", {31'h0, DONE}, 32'd0);
        chk("rst_data_out", {24'h0, Data_out}, 32'h0);
        chk("rst_wready", {31'h0, DEV_WREADY}, 32'd1);
        chk("rst_rvalid", {31'h0, DEV_RVALID}, 32'd0);
        chk("rst_z_rdy", {31'h0, z_RDY}, 32'd1);
        RST = 1'b1;
        tick;

        // Zero wait states: RDY never drops, one byte per IOR cycle.
        b0 = 8'($urandom_range(1, 255));
        b1 = 8'($urandom_range(1, 255));
        z_DEV_WDATA = b0; z_DEV_WVALID = 1'b1; tick;
        z_DEV_WDATA = b1; tick;
        z_DEV_WVALID = 1'b0;
        k = 0;
        while (!z_DREQ && k < 20) begin tick; k++; end
        chk("z_dreq", {31'h0, z_DREQ}, 32'd1);
        z_DACK = 1'b1; tick;
        z_IOR = 1'b1; #1;
        chk("z_rdy0", {31'h0, z_RDY}, 32'd1);
        chk("z_byte0", {24'h0, z_Data_out}, {24'h0, b0});
        tick;
        chk("z_rdy1", {31'h0, z_RDY}, 32'd1);
        chk("z_byte1", {24'h0, z_Data_out}, {24'h0, b1});
        tick;
        chk("z_rdy2", {31'h0, z_RDY}, 32'd1);
        chk("z_empty_out", {24'h0, z_Data_out}, 32'h0);
        chk("z_dreq_low", {31'h0, z_DREQ}, 32'd0);
        z_IOR = 1'b0; z_DACK = 1'b0; tick;

        // Source transfer of three fixed bytes.
        dev_push_byte(8'h05);
        dev_push_byte(8'h0A);
        dev_push_byte(8'h0F);
        open_xfer;
        IOR = 1'b1;
        bus_read(3, 1'b0);
        chk("src_dreq_after_last", {31'h0, DREQ}, 32'd0);
        IOR = 1'b0; DACK = 1'b0; tick;

        // Sink: two bytes in, drained in order on the device side.
        MODE = 1'b1;
        tick;
        open_xfer;
        bytes[0] = 8'h8A; bytes[1] = 8'h8B; bytes[2] = 8'h00; bytes[3] = 8'h00;
        bus_write(2, bytes);
        DACK = 1'b0; tick;
        drain(2);

        // MODE flip outside IDLE is held off.
        MODE = 1'b0; tick;
        chk("mode_locked_wready", {31'h0, DEV_WREADY}, 32'd0);
        MODE = 1'b1;

        // Sink fill to four, then a fifth write that must be ignored.
        open_xfer;
        for (int i = 0; i < 4; i++) bytes[i] = 8'($urandom);
        bus_write(4, bytes);
        chk("snk_full_dreq", {31'h0, DREQ}, 32'd0);
        Data_in = 8'($urandom); IOW = 1'b1;
        repeat (4) tick;
        chk("snk_overflow_dreq", {31'h0, DREQ}, 32'd0);
        IOW = 1'b0; DACK = 1'b0; tick;
        drain(4);

        // EOP from REQ, then switch back to source via DONE_CLR.
        wait_dreq("dreq_before_eop");
        EOP = 1'b1; tick; EOP = 1'b0;
        chk("done_from_req", {31'h0, DONE}, 32'd1);
        chk("done_rdy", {31'h0, RDY}, 32'd1);
        MODE = 1'b0; DONE_CLR = 1'b1; tick; DONE_CLR = 1'b0;
        chk("done_cleared", {31'h0, DONE}, 32'd0);

        // EOP coincident with the final IOR.
        dev_push_byte(8'($urandom));
        dev_push_byte(8'($urandom));
        open_xfer;
        IOR = 1'b1;
        wait_rdy;
        tick;
        wait_rdy;
        EOP = 1'b1; tick; EOP = 1'b0;
        chk("eop_done", {31'h0, DONE}, 32'd1);
        chk("eop_dreq", {31'h0, DREQ}, 32'd0);
        chk("eop_rdy", {31'h0, RDY}, 32'd1);
        tick; tick;
        chk("eop_done_held", {31'h0, DONE}, 32'd1);
        IOR = 1'b0; DACK = 1'b0; DONE_CLR = 1'b1; tick; DONE_CLR = 1'b0;
        chk("eop_done_clr", {31'h0, DONE}, 32'd0);
        tick; tick;
        chk("eop_byte_popped", {31'h0, DREQ}, 32'd0);

        // Reset in the middle of a transfer with three bytes queued.
        dev_push_byte(8'($urandom));
        dev_push_byte(8'($urandom));
        dev_push_byte(8'($urandom));
        open_xfer;
        chk("xfer_wait_rdy", {31'h0, RDY}, 32'd0);
        RST = 1'b0; tick;
        chk("midrst_dreq", {31'h0, DREQ}, 32'd0);
        chk("midrst_rdy", {31'h0, RDY}, 32'd1);
        chk("midrst_done", {31'h0, DONE}, 32'd0);
        RST = 1'b1; DACK = 1'b0;
        exp_bus_q.delete();
        tick; tick;
        chk("midrst_flushed", {31'h0, DREQ}, 32'd0);

        // Randomized transfers in both directions.
        for (int it = 0; it < 10; it++) begin
            m = 1'($urandom_range(0, 1));
            k = $urandom_range(1, 4);
            RST = 1'b0; MODE = m; DACK = 1'b0; IOR = 1'b0; IOW = 1'b0;
            tick;
            RST = 1'b1;
            if (m == 1'b0) begin
                for (int i = 0; i < k; i++) dev_push_byte(8'($urandom));
                open_xfer;
                IOR = 1'b1;
                bus_read(k, 1'b1);
                chk("rnd_src_dreq_end", {31'h0, DREQ}, 32'd0);
                IOR = 1'b0; DACK = 1'b0; tick;
            end else begin
                open_xfer;
                for (int i = 0; i < 4; i++) bytes[i] = 8'($urandom);
                bus_write(k, bytes);
                chk("rnd_snk_dreq_end", {31'h0, DREQ}, {31'h0, (k < 4)});
                DACK = 1'b0; tick;
                drain(k);
            end
        end

        tick;
        chk("bus_queue_drained", exp_bus_q.size(), 0);
        chk("dev_queue_drained", exp_dev_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
